// File: rtl/ram_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port RAM with one-cycle read latency.
// Optional address bounds checking is enabled by defining RAM_ARB_BOUNDS_EN.
//
// Handshake: a requester holds REQ/ADDR/WDATA stable until it sees GNT high in the same cycle;
// exactly one RVALID pulse follows each GNT in the next cycle, carrying RDATA (0 for store acks
// and out-of-range accesses). There is no backpressure on the response side.
module ram_arbiter #(
    parameter int XLEN       = 32,
    parameter int RAM_SIZE   = 'h600,
    parameter int STARVE_MAX = 4
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        I_REQ,
    input  logic [XLEN-1:0]             I_ADDR,
    output logic                        I_GNT,
    output logic                        I_RVALID,
    output logic [31:0]                 I_RDATA,
    input  logic                        D_REQ,
    input  logic                        D_WE,
    input  logic [3:0]                  D_WSTRB,
    input  logic [XLEN-1:0]             D_ADDR,
    input  logic [31:0]                 D_WDATA,
    output logic                        D_GNT,
    output logic                        D_RVALID,
    output logic [31:0]                 D_RDATA,
    output logic                        MEM_EN,
    output logic [3:0]                  MEM_WE,
    output logic [$clog2(RAM_SIZE)-1:0] MEM_ADDR,
    output logic [31:0]                 MEM_WDATA,
    input  logic [31:0]                 MEM_RDATA,
    output logic                        ERR
);

    localparam int AW = $clog2(RAM_SIZE);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t          owner;
    logic            store_q;
    logic            err_q;
    logic [3:0]      starve_cnt;

    logic            i_sel;
    logic            any_gnt;
    logic            oor;
    logic [XLEN-1:0] g_addr;
    logic            unused_addr;

    always_comb begin
        i_sel   = I_REQ && (!D_REQ || (starve_cnt == 4'(STARVE_MAX)));
        I_GNT   = RESETN && i_sel;
        D_GNT   = RESETN && D_REQ && !i_sel;
        any_gnt = I_GNT || D_GNT;
        g_addr  = I_GNT ? I_ADDR : D_ADDR;
    end

`ifdef RAM_ARB_BOUNDS_EN
    // Out of range: index past the array, or any address bit above the index field set.
    always_comb begin
        oor = (XLEN'(g_addr[AW+1:2]) >= XLEN'(RAM_SIZE)) || ((g_addr >> (AW + 2)) != '0);
    end
    assign unused_addr = ^g_addr[1:0];
`else
    always_comb begin
        oor = 1'b0;
    end
    assign unused_addr = ^{g_addr[XLEN-1:AW+2], g_addr[1:0]};
`endif

    always_comb begin
        MEM_EN    = any_gnt && !oor;
        MEM_WE    = (D_GNT && D_WE && !oor) ? D_WSTRB : 4'b0000;
        MEM_ADDR  = g_addr[AW+1:2];
        MEM_WDATA = D_GNT ? D_WDATA : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            owner      <= OWN_NONE;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            owner   <= I_GNT ? OWN_I : (D_GNT ? OWN_D : OWN_NONE);
            store_q <= D_GNT && D_WE;
            err_q   <= any_gnt && oor;
            if (!I_REQ || I_GNT) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Read data is passed straight through from the RAM in the response cycle.
    always_comb begin
        I_RVALID = (owner == OWN_I);
        D_RVALID = (owner == OWN_D);
        I_RDATA  = (I_RVALID && !err_q) ? MEM_RDATA : 32'h0;
        D_RDATA  = (D_RVALID && !err_q && !store_q) ? MEM_RDATA : 32'h0;
        ERR      = err_q;
    end

endmodule
